// File: rtl/pipemem_lsu.sv
// pipemem_lsu: MEM-stage load/store unit bridging a pipelined CPU to a single-beat ack bus.
// Ports:
//   clock, resetn                 rising-edge clock, asynchronous active-low reset
//   mvalid, mcancel               MEM-stage instruction valid / flush
//   mwmem, mm2reg, msize, msext   store, load, size (00 word, 01 half, 10 byte, 11 word), sign-extend
//   malu, mb                      effective address or pass-through result, store data
//   dreq, dwe, daddr, dbe, dwdata bus request, write enable, word address, byte enables, write data
//   dack, drdata                  bus acknowledge and read data
//   mdata                         load result, or malu for non-loads
//   mem_stall                     holds the pipeline while an access is in flight
//   mexc, mexc_code, mbadaddr     exception pulse, code (01 ld misalign, 10 st misalign, 11 timeout), address
module pipemem_lsu (
  input  logic        clock,
  input  logic        resetn,
  input  logic        mvalid,
  input  logic        mcancel,
  input  logic        mwmem,
  input  logic        mm2reg,
  input  logic [1:0]  msize,
  input  logic        msext,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  output logic        dreq,
  output logic        dwe,
  output logic [31:0] daddr,
  output logic [3:0]  dbe,
  output logic [31:0] dwdata,
  input  logic        dack,
  input  logic [31:0] drdata,
  output logic [31:0] mdata,
  output logic        mem_stall,
  output logic        mexc,
  output logic [1:0]  mexc_code,
  output logic [31:0] mbadaddr
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;
  state_t      state_q, state_d;
  logic        dreq_q, dreq_d, dwe_q, dwe_d;
  logic [31:0] addr_q, addr_d, dwdata_q, dwdata_d, ld_q, ld_d;
  logic [3:0]  dbe_q, dbe_d, wait_q, wait_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d, ldf_q, ldf_d, tmo_q, tmo_d, cxl_q, cxl_d;
  logic        acc, mis, mis_exc, tmo_exc;
  logic [3:0]  be;
  logic [31:0] wd, sh, ld_ext;
  assign acc = mvalid & ~mcancel & (mwmem | mm2reg);
  assign mis = (msize == 2'b01) ? malu[0] : (msize == 2'b10) ? 1'b0 : |malu[1:0];
  assign be  = (msize == 2'b10) ? 4'b0001 << malu[1:0] :
               (msize == 2'b01) ? (malu[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd  = (msize == 2'b10) ? {4{mb[7:0]}} : (msize == 2'b01) ? {2{mb[15:0]}} : mb;
  always_comb begin
    state_d  = state_q;
    dreq_d   = dreq_q;
    dwe_d    = dwe_q;
    addr_d   = addr_q;
    dbe_d    = dbe_q;
    dwdata_d = dwdata_q;
    ld_d     = ld_q;
    wait_d   = wait_q;
    size_d   = size_q;
    sext_d   = sext_q;
    ldf_d    = ldf_q;
    tmo_d    = tmo_q;
    cxl_d    = cxl_q;
    if (state_q == IDLE) begin
      if (acc && !mis) begin
        state_d  = REQ;
        dreq_d   = 1'b1;
        dwe_d    = mwmem;
        addr_d   = malu;
        dbe_d    = be;
        dwdata_d = wd;
        size_d   = msize;
        sext_d   = msext;
        ldf_d    = mm2reg & ~mwmem;
        wait_d   = 4'd0;
        tmo_d    = 1'b0;
        cxl_d    = 1'b0;
      end
    end else if (state_q == REQ) begin
      // A flush here lets the bus cycle finish but remembers to mute its exception.
      cxl_d = cxl_q | mcancel;
      if (dack) begin
        ld_d    = drdata;
        dreq_d  = 1'b0;
        dwe_d   = 1'b0;
        state_d = DONE;
      end else if (wait_q == 4'd15) begin
        dreq_d  = 1'b0;
        dwe_d   = 1'b0;
        tmo_d   = 1'b1;
        state_d = DONE;
      end else begin
        wait_d = wait_q + 4'd1;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      dreq_q   <= 1'b0;
      dwe_q    <= 1'b0;
      addr_q   <= 32'd0;
      dbe_q    <= 4'd0;
      dwdata_q <= 32'd0;
      ld_q     <= 32'd0;
      wait_q   <= 4'd0;
      size_q   <= 2'd0;
      sext_q   <= 1'b0;
      ldf_q    <= 1'b0;
      tmo_q    <= 1'b0;
      cxl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dreq_q   <= dreq_d;
      dwe_q    <= dwe_d;
      addr_q   <= addr_d;
      dbe_q    <= dbe_d;
      dwdata_q <= dwdata_d;
      ld_q     <= ld_d;
      wait_q   <= wait_d;
      size_q   <= size_d;
      sext_q   <= sext_d;
      ldf_q    <= ldf_d;
      tmo_q    <= tmo_d;
      cxl_q    <= cxl_d;
    end
  end
  assign sh     = ld_q >> {addr_q[1:0], 3'b000};
  assign ld_ext = (size_q == 2'b10) ? {{24{sext_q & sh[7]}}, sh[7:0]} :
                  (size_q == 2'b01) ? {{16{sext_q & sh[15]}}, sh[15:0]} : ld_q;
  assign mis_exc   = (state_q == IDLE) & acc & mis;
  assign tmo_exc   = (state_q == DONE) & tmo_q & ~cxl_q;
  assign dreq      = dreq_q;
  assign dwe       = dwe_q;
  assign daddr     = {addr_q[31:2], 2'b00};
  assign dbe       = dbe_q;
  assign dwdata    = dwdata_q;
  assign mdata     = (state_q == DONE && ldf_q) ? ld_ext : malu;
  assign mem_stall = ((state_q == IDLE) & acc & ~mis) | (state_q == REQ);
  assign mexc      = mis_exc | tmo_exc;
  assign mexc_code = mis_exc ? (mwmem ? 2'b10 : 2'b01) : tmo_exc ? 2'b11 : 2'b00;
  assign mbadaddr  = mis_exc ? malu : tmo_exc ? addr_q : 32'd0;
endmodule

// File: doc/pipemem_lsu.md
PIPEMEM_LSU -- requirements
Module: pipemem_lsu

Interface
REQ-001 SHALL have ports, in order: clock in 1 (rising-edge system clock); resetn in 1 (asynchronous, active-low reset).
REQ-002 SHALL have mvalid in 1: an instruction occupies the MEM stage and has not been cancelled.
REQ-003 SHALL have mcancel in 1: an interrupt/exception flush of the MEM stage instruction.
REQ-004 SHALL have mwmem in 1 (store), mm2reg in 1 (load), msize in 2 (00 word, 01 half, 10 byte, 11 reserved, treated as word), msext in 1 (sign-extend loads).
REQ-005 SHALL have malu in 32 (EXE-stage ALU result: effective address, or the pass-through result) and mb in 32 (store data).
REQ-006 SHALL have bus ports: dreq out 1, dwe out 1, daddr out 32 (word-aligned, bits[1:0]=00), dbe out 4, dwdata out 32, dack in 1, drdata in 32.
REQ-007 SHALL have mdata out 32 (load result, or malu for non-load), mem_stall out 1, mexc out 1, mexc_code out 2 (01 load misalign, 10 store misalign, 11 bus timeout), mbadaddr out 32.

Function
REQ-008 SHALL implement FSM states IDLE, REQ, DONE, encoded in 2 bits.
REQ-009 Access condition SHALL be: mvalid & ~mcancel & (mwmem | mm2reg).
REQ-010 Misalignment SHALL be: half with malu[0]=1, or word with malu[1:0]≠00.
REQ-011 IDLE, access and aligned: SHALL assert mem_stall combinationally, latch address/size/sext/store-data/dbe at the clock edge, and go to REQ.
REQ-012 IDLE, access and misaligned: SHALL issue no request, keep mem_stall=0, and pulse mexc=1 with the matching code and mbadaddr=malu for that cycle only.
REQ-013 REQ: SHALL drive dreq=1 and dwe=latched store flag, hold mem_stall=1, and hold all bus outputs stable until dack.
REQ-014 REQ with dack=1: SHALL capture drdata into the load register and go to DONE.
REQ-015 REQ SHALL increment a 4-bit wait counter (cleared on entry to REQ) each cycle without dack.
REQ-016 If the wait counter is 15 and dack=0: SHALL drop dreq next cycle, go to DONE, and set mexc=1, code 11, mbadaddr=latched address during DONE.
REQ-017 DONE: SHALL hold mem_stall=0 and present the result on mdata for exactly one cycle, then go to IDLE.
REQ-018 mcancel in REQ SHALL NOT abort the bus cycle: the transaction completes, and DONE suppresses mexc.
REQ-019 Store byte enables: word 1111; half 0011 when a[1]=0, else 1100; byte one-hot 0001<<a[1:0].
REQ-020 Store data SHALL be replicated: half {2{mb[15:0]}}, byte {4{mb[7:0]}}.
REQ-021 Load data SHALL be shifted by the latched a[1:0], then zero- or sign-extended from 8/16 bits per msext.
REQ-022 mdata SHALL be combinational: the processed load register in DONE when the load flag is latched, else malu.
REQ-023 Minimum MEM occupancy SHALL be 3 cycles (IDLE, REQ, DONE) with dack in the first REQ cycle; non-memory instructions take 1 cycle with no stall.
REQ-024 Simultaneous mwmem and mm2reg SHALL be treated as a store.

Reset
REQ-025 resetn=0 SHALL asynchronously force: state IDLE, dreq=0, dwe=0, daddr=0, dbe=0, dwdata=0, wait counter=0, load register=0, mexc=0, mexc_code=00, mbadaddr=0.
REQ-026 Reset asserted mid-REQ SHALL abandon the transaction, with dreq low in the same cycle.

Verification
REQ-027 Load word: malu=0x100, dack in the first REQ cycle, drdata=0xDEADBEEF -> stall for 2 cycles; mdata=0xDEADBEEF in DONE.
REQ-028 Signed byte load: malu=0x103, msext=1, drdata=0x80000000 -> dbe unused; mdata=0xFFFFFF80. With msext=0 -> 0x00000080.
REQ-029 Half store: malu=0x202, mb=0x1234ABCD -> daddr=0x200, dbe=1100, dwdata=0xABCDABCD, dwe=1.
REQ-030 Misaligned word load: malu=0x101 -> no dreq, mexc=1, code 01, mbadaddr=0x101, mem_stall=0.
REQ-031 No dack for 16 REQ cycles -> dreq drops, mexc=1, code 11 in DONE, FSM returns to IDLE.
REQ-032 resetn low during REQ -> dreq=0 immediately, FSM in IDLE after release, next access proceeds normally.
